// File: rtl/deconv_pkg.sv
// Shared types and helpers for the stream deconvolver.
// Optional feature macro: DECONV_EXACT_CHECK_EN (remainder / inexact flag).
`timescale 1ns/1ps
package deconv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DIV,
        OUT
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic longint sat_max(input int xw);
        return (longint'(1) <<< (xw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int xw);
        return -(longint'(1) <<< (xw - 1));
    endfunction

endpackage

// File: rtl/stream_deconvolver_serial_sdiv.sv
// Restoring signed serial divider, one quotient bit per cycle, truncating.
// Remainder port exists only when DECONV_EXACT_CHECK_EN is defined.
`timescale 1ns/1ps
module serial_sdiv
    import deconv_pkg::*;
#(
    parameter int ACCW = 45,
    parameter int XW   = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic signed [ACCW-1:0] dividend,
    input  logic signed [XW-1:0]   divisor,
    output logic                   done,
    output logic signed [ACCW-1:0] quotient
`ifdef DECONV_EXACT_CHECK_EN
    ,
    output logic signed [XW-1:0]   remainder
`endif
);

    localparam int CW = clog2(ACCW);

    logic [XW-1:0]   rem_q, rem_d;
    logic [ACCW-1:0] quo_q, quo_d;
    logic [XW-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;

    logic [ACCW-1:0] a_mag, d_in, d_nx;
    logic [XW-1:0]   b_mag, r_in, m_in;
    logic [XW:0]     r_sh;
    logic            ge;

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        negq_d = negq_q;
        negr_d = negr_q;
        done_d = 1'b0;
        a_mag  = dividend[ACCW-1] ? -dividend : dividend;
        b_mag  = divisor[XW-1] ? -divisor : divisor;
        // Start edge already performs the first step on the fresh operands.
        if (start) begin
            r_in = '0;
            d_in = a_mag;
            m_in = b_mag;
        end else begin
            r_in = rem_q;
            d_in = quo_q;
            m_in = dvs_q;
        end
        r_sh = {r_in, d_in[ACCW-1]};
        ge   = r_sh >= {1'b0, m_in};
        d_nx = {d_in[ACCW-2:0], ge};
        if (start) begin
            rem_d  = XW'(ge ? r_sh - {1'b0, m_in} : r_sh);
            quo_d  = d_nx;
            dvs_d  = b_mag;
            cnt_d  = CW'(ACCW - 1);
            busy_d = 1'b1;
            negq_d = dividend[ACCW-1] ^ divisor[XW-1];
            negr_d = dividend[ACCW-1];
        end else if (busy_q) begin
            rem_d = XW'(ge ? r_sh - {1'b0, m_in} : r_sh);
            quo_d = d_nx;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
        end
    end

    assign done     = done_q;
    assign quotient = negq_q ? (~quo_q + 1'b1) : quo_q;
`ifdef DECONV_EXACT_CHECK_EN
    assign remainder = negr_q ? (~rem_q + 1'b1) : rem_q;
`endif

endmodule

// File: rtl/stream_deconvolver.sv
// Recovers x from y = x * h by causal recursion and a serial divider.
// Optional x_inexact output when DECONV_EXACT_CHECK_EN is defined.
`timescale 1ns/1ps
module stream_deconvolver
    import deconv_pkg::*;
#(
    parameter int K  = 4,
    parameter int XW = 21,
    parameter int YW = 42
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   h_we,
    input  logic [((K > 1) ? clog2(K) : 1)-1:0]    h_addr,
    input  logic signed [XW-1:0]                   h_data,
    input  logic                                   y_valid,
    output logic                                   y_ready,
    input  logic signed [YW-1:0]                   y_data,
    input  logic                                   y_last,
    output logic                                   x_valid,
    input  logic                                   x_ready,
    output logic signed [XW-1:0]                   x_data,
    output logic                                   x_last,
    output logic                                   busy,
    output logic                                   err_div0,
    output logic                                   err_sat
`ifdef DECONV_EXACT_CHECK_EN
    ,
    output logic                                   x_inexact
`endif
);

    localparam int AW   = (K > 1) ? clog2(K) : 1;
    localparam int ACCW = YW + clog2(K) + 1;
    localparam int HN   = (K > 1) ? K - 1 : 1;
    localparam logic signed [ACCW-1:0] QMAX = ACCW'(sat_max(XW));
    localparam logic signed [ACCW-1:0] QMIN = ACCW'(sat_min(XW));

    state_e                 state_q, state_d;
    logic signed [XW-1:0]   h_q [K];
    logic signed [XW-1:0]   h_d [K];
    logic signed [XW-1:0]   hist_q [HN];
    logic signed [XW-1:0]   hist_d [HN];
    logic signed [ACCW-1:0] res_q, res_d;
    logic [AW-1:0]          kidx_q, kidx_d;
    logic                   last_q, last_d;
    logic                   div0_q, div0_d;
    logic                   y_ready_q, y_ready_d;
    logic                   x_valid_q, x_valid_d;
    logic signed [XW-1:0]   x_data_q, x_data_d;
    logic                   x_last_q, x_last_d;
    logic                   err_div0_q, err_div0_d;
    logic                   err_sat_q, err_sat_d;

    logic signed [2*XW-1:0] prod;
    logic                   div_start, div_done;
    logic signed [ACCW-1:0] div_quo;
    logic signed [XW-1:0]   clamped;
    logic                   clamp_hit;
`ifdef DECONV_EXACT_CHECK_EN
    logic signed [XW-1:0]   div_rem;
    logic                   x_inexact_q, x_inexact_d;
`endif

    assign prod = h_q[kidx_q] * hist_q[kidx_q - 1'b1];

    always_comb begin
        clamp_hit = 1'b1;
        if (div_quo > QMAX) begin
            clamped = QMAX[XW-1:0];
        end else if (div_quo < QMIN) begin
            clamped = QMIN[XW-1:0];
        end else begin
            clamped   = div_quo[XW-1:0];
            clamp_hit = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        hist_d     = hist_q;
        res_d      = res_q;
        kidx_d     = kidx_q;
        last_d     = last_q;
        div0_d     = div0_q;
        x_valid_d  = x_valid_q;
        x_data_d   = x_data_q;
        x_last_d   = x_last_q;
        err_div0_d = err_div0_q;
        err_sat_d  = err_sat_q;
        div_start  = 1'b0;
`ifdef DECONV_EXACT_CHECK_EN
        x_inexact_d = x_inexact_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (h_we && (32'(h_addr) < K)) begin
                    h_d[h_addr] = h_data;
                    err_div0_d  = 1'b0;
                    err_sat_d   = 1'b0;
                end
                if (y_valid && y_ready_q) begin
                    res_d  = ACCW'(y_data);
                    last_d = y_last;
                    if (K > 1) begin
                        state_d = MAC;
                        kidx_d  = AW'(1);
                    end else begin
                        state_d   = DIV;
                        div_start = (h_q[0] != '0);
                        div0_d    = (h_q[0] == '0);
                    end
                end
            end
            MAC: begin
                res_d = res_q - ACCW'(prod);
                // Divider is launched on the final residual, so DIV is exactly ACCW cycles.
                if (32'(kidx_q) == K - 1) begin
                    state_d   = DIV;
                    div_start = (h_q[0] != '0);
                    div0_d    = (h_q[0] == '0);
                end else begin
                    kidx_d = kidx_q + 1'b1;
                end
            end
            DIV: begin
                if (div0_q) begin
                    state_d    = OUT;
                    x_valid_d  = 1'b1;
                    x_data_d   = '0;
                    x_last_d   = last_q;
                    err_div0_d = 1'b1;
`ifdef DECONV_EXACT_CHECK_EN
                    x_inexact_d = 1'b0;
`endif
                end else if (div_done) begin
                    state_d   = OUT;
                    x_valid_d = 1'b1;
                    x_data_d  = clamped;
                    x_last_d  = last_q;
                    if (clamp_hit) err_sat_d = 1'b1;
`ifdef DECONV_EXACT_CHECK_EN
                    x_inexact_d = (div_rem != '0);
`endif
                end
            end
            OUT: begin
                if (x_ready) begin
                    state_d   = IDLE;
                    x_valid_d = 1'b0;
                    hist_d[0] = x_data_q;
                    for (int i = 1; i < HN; i++) hist_d[i] = hist_q[i-1];
                    if (x_last_q) begin
                        for (int i = 0; i < HN; i++) hist_d[i] = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        y_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            for (int i = 0; i < K; i++) h_q[i] <= '0;
            for (int i = 0; i < HN; i++) hist_q[i] <= '0;
            res_q      <= '0;
            kidx_q     <= '0;
            last_q     <= 1'b0;
            div0_q     <= 1'b0;
            y_ready_q  <= 1'b0;
            x_valid_q  <= 1'b0;
            x_data_q   <= '0;
            x_last_q   <= 1'b0;
            err_div0_q <= 1'b0;
            err_sat_q  <= 1'b0;
`ifdef DECONV_EXACT_CHECK_EN
            x_inexact_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            hist_q     <= hist_d;
            res_q      <= res_d;
            kidx_q     <= kidx_d;
            last_q     <= last_d;
            div0_q     <= div0_d;
            y_ready_q  <= y_ready_d;
            x_valid_q  <= x_valid_d;
            x_data_q   <= x_data_d;
            x_last_q   <= x_last_d;
            err_div0_q <= err_div0_d;
            err_sat_q  <= err_sat_d;
`ifdef DECONV_EXACT_CHECK_EN
            x_inexact_q <= x_inexact_d;
`endif
        end
    end

    serial_sdiv #(
        .ACCW(ACCW),
        .XW  (XW)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (res_d),
        .divisor  (h_q[0]),
        .done     (div_done),
        .quotient (div_quo)
`ifdef DECONV_EXACT_CHECK_EN
        ,
        .remainder(div_rem)
`endif
    );

    assign y_ready  = y_ready_q;
    assign x_valid  = x_valid_q;
    assign x_data   = x_data_q;
    assign x_last   = x_last_q;
    assign busy     = (state_q != IDLE);
    assign err_div0 = err_div0_q;
    assign err_sat  = err_sat_q;
`ifdef DECONV_EXACT_CHECK_EN
    assign x_inexact = x_inexact_q;
`endif

endmodule

// File: tb/tb_stream_deconvolver.sv
// Directed plus randomized bench for stream_deconvolver against a recursion model.
// Covers x_inexact when DECONV_EXACT_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_stream_deconvolver;

    localparam int K    = 4;
    localparam int XW   = 21;
    localparam int YW   = 42;
    localparam int ACCW = YW + $clog2(K) + 1;
    localparam longint SMAX = (longint'(1) <<< (XW - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (XW - 1));

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 h_we = 1'b0;
    logic [1:0]           h_addr = '0;
    logic signed [XW-1:0] h_data = '0;
    logic                 y_valid = 1'b0;
    logic                 y_ready;
    logic signed [YW-1:0] y_data = '0;
    logic                 y_last = 1'b0;
    logic                 x_valid;
    logic                 x_ready = 1'b0;
    logic signed [XW-1:0] x_data;
    logic                 x_last;
    logic                 busy;
    logic                 err_div0;
    logic                 err_sat;
`ifdef DECONV_EXACT_CHECK_EN
    logic                 x_inexact;
`endif

    always #5 clk = ~clk;

    stream_deconvolver #(.K(K), .XW(XW), .YW(YW)) dut (
        .clk      (clk),
        .rst      (rst),
        .h_we     (h_we),
        .h_addr   (h_addr),
        .h_data   (h_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_data   (y_data),
        .y_last   (y_last),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .x_data   (x_data),
        .x_last   (x_last),
        .busy     (busy),
        .err_div0 (err_div0),
        .err_sat  (err_sat)
`ifdef DECONV_EXACT_CHECK_EN
        ,
        .x_inexact(x_inexact)
`endif
    );

    int checks   = 0;
    int failures = 0;

    longint hm [K];
    longint xh [K];
    bit     m_div0;
    bit     m_sat;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < K; i++) begin
            hm[i] = 0;
            xh[i] = 0;
        end
        m_div0 = 1'b0;
        m_sat  = 1'b0;
    endtask

    task automatic wr(input int a, input longint d);
        @(negedge clk);
        h_we   = 1'b1;
        h_addr = 2'(a);
        h_data = XW'(d);
        @(posedge clk);
        #1;
        h_we = 1'b0;
        hm[a]  = d;
        m_div0 = 1'b0;
        m_sat  = 1'b0;
    endtask

    task automatic send(input longint y, input bit last, input int stall,
                        input bit wr_mac);
        longint r, q, xe;
        bit     inex, dz;
        int     cyc, lat;
        r = y;
        for (int k = 1; k < K; k++) r -= hm[k] * xh[k-1];
        if (hm[0] == 0) begin
            q = 0; inex = 1'b0; dz = 1'b1;
        end else begin
            q = r / hm[0]; inex = (r % hm[0]) != 0; dz = 1'b0;
        end
        if (q > SMAX) begin
            xe = SMAX; m_sat = 1'b1;
        end else if (q < SMIN) begin
            xe = SMIN; m_sat = 1'b1;
        end else begin
            xe = q;
        end
        if (dz) m_div0 = 1'b1;
        lat = dz ? 1 + (K - 1) + 1 : 1 + (K - 1) + ACCW;

        @(negedge clk);
        y_valid = 1'b1;
        y_data  = YW'(y);
        y_last  = last;
        cyc = 0;
        while (!y_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("accept_ready", y_ready, 1);
        @(posedge clk);
        #1;
        y_valid = 1'b0;
        cyc = 0;
        if (wr_mac) begin
            h_we   = 1'b1;
            h_addr = 2'd1;
            h_data = 21'sd5;
            @(posedge clk);
            #1;
            h_we = 1'b0;
            cyc  = 1;
        end
        while (!x_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", cyc + 1, lat);
        chk("busy_out", busy, 1);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", x_valid, 1);
            chk("stall_data", x_data, xe);
        end
        chk("x_data", x_data, xe);
        chk("x_last", x_last, last);
        chk("err_div0", err_div0, m_div0);
        chk("err_sat", err_sat, m_sat);
`ifdef DECONV_EXACT_CHECK_EN
        chk("x_inexact", x_inexact, inex);
`endif
        x_ready = 1'b1;
        @(posedge clk);
        #1;
        x_ready = 1'b0;
        chk("valid_drop", x_valid, 0);
        chk("ready_back", y_ready, 1);
        if (last) begin
            for (int i = 0; i < K; i++) xh[i] = 0;
        end else begin
            for (int i = K - 1; i > 0; i--) xh[i] = xh[i-1];
            xh[0] = xe;
        end
    endtask

    function automatic longint rnd_h();
        logic signed [18:0] t;
        t = 19'($urandom);
        return longint'(t);
    endfunction

    function automatic longint rnd_y();
        logic signed [39:0] t;
        t = 40'({$urandom, $urandom});
        return longint'(t);
    endfunction

    initial begin
        longint hv, yv, xt;
        int     cyc;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_y_ready", y_ready, 0);
        chk("rst_x_valid", x_valid, 0);
        chk("rst_x_data", x_data, 0);
        chk("rst_x_last", x_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_div0", err_div0, 0);
        chk("rst_err_sat", err_sat, 0);
        rst = 1'b0;
        #1;
        chk("ready_pre_edge", y_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_post_edge", y_ready, 1);

        // Identity kernel
        wr(0, 1);
        send(5, 1'b0, 0, 1'b0);
        send(-3, 1'b1, 0, 1'b0);

        // Two-tap recursion
        wr(0, 2);
        wr(1, 1);
        send(6, 1'b0, 0, 1'b0);
        send(11, 1'b0, 0, 1'b0);
        send(2, 1'b1, 0, 1'b0);

        // Frame boundary with backpressure
        send(6, 1'b1, 5, 1'b0);
        send(6, 1'b1, 5, 1'b0);

        // Divide by zero
        wr(0, 0);
        send(7, 1'b1, 0, 1'b0);
        wr(0, 1);
        chk("div0_cleared", err_div0, 0);

        // Saturation
        wr(1, 0);
        send(longint'(1) <<< 30, 1'b1, 0, 1'b0);
        send(-(longint'(1) <<< 30), 1'b1, 0, 1'b0);

        // Reset in the middle of DIV
        wr(0, 2);
        wr(1, 1);
        send(6, 1'b0, 0, 1'b0);
        @(negedge clk);
        y_valid = 1'b1;
        y_data  = 42'sd20;
        y_last  = 1'b0;
        cyc = 0;
        while (!y_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
        y_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", x_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", y_ready, 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("post_rst_valid", x_valid, 0);
        wr(0, 2);
        wr(1, 1);
        send(6, 1'b1, 0, 1'b0);

        // Kernel write during MAC is ignored
        send(6, 1'b0, 0, 1'b1);
        send(10, 1'b1, 0, 1'b0);

        // Randomized kernel and samples
        for (int i = 0; i < K; i++) begin
            hv = rnd_h();
            if (i == 0 && hv == 0) hv = 3;
            wr(i, hv);
        end
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                xt = longint'($urandom_range(0, 2000)) - 1000;
                yv = xt * hm[0];
                for (int k = 1; k < K; k++) yv += hm[k] * xh[k-1];
            end else begin
                yv = rnd_y();
            end
            send(yv, $urandom_range(0, 3) == 0, $urandom_range(0, 3), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
